alu_elem_sequencer: RTL and testbench

Element sequencer that drives the vector ALU from the issue side and collects its results. It accepts one vector-arithmetic request (opcode, vector length, masking), reads operands element by element from the lane register file and issues them to the ALU. It tracks every in-flight element through the fixed ALU pipeline latency and generates register-file writebacks with the correct element index. It signals completion once the last element has retired.

---
 rtl/alu_elem_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_elem_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_elem_sequencer.sv
// rtl/alu_elem_sequencer.sv - element sequencer feeding the vector ALU and retiring its results
//
// Accepts one vector request (opcode, element count, masking), reads operands
// element by element from the lane register file, issues them to the ALU and
// follows every issued element through the fixed ALU latency to generate the
// register-file writeback with the correct element index.
//
// Ports:
//   clk_i, resetn_i               clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       request handshake
//   req_ocode_i/vl_i/masked_i     request opcode, element count (0..VLEN_MAX), masking enable
//   stall_i                       hold operand issue this cycle
//   rd_en_o/rd_idx_o              operand read strobe and element index
//   rd_a/b/c_i, rd_mask_i         combinational operand read data and mask bit
//   alu_valid_o, alu_mask_e_o     registered ALU operand valid and mask/carry bit
//   alu_a/b/c_o, alu_ocode_o      registered operands, latched opcode
//   alu_q_i                       ALU result, PIPE_ST cycles after alu_valid_o
//   wb_en_o/wb_idx_o/wb_data_o    register-file writeback
//   busy_o, done_o                not idle, one-cycle completion pulse
module alu_elem_sequencer #(
    parameter int  DATA_WIDTH = 32,
    parameter int  PIPE_ST    = 3,
    parameter int  VLEN_MAX   = 32,
    localparam int IDX_W      = $clog2(VLEN_MAX)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [6:0]            req_ocode_i,
    input  logic [IDX_W:0]        req_vl_i,
    input  logic                  req_masked_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [IDX_W-1:0]      rd_idx_o,
    input  logic [DATA_WIDTH-1:0] rd_a_i,
    input  logic [DATA_WIDTH-1:0] rd_b_i,
    input  logic [DATA_WIDTH-1:0] rd_c_i,
    input  logic                  rd_mask_i,
    output logic                  alu_valid_o,
    output logic                  alu_mask_e_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [DATA_WIDTH-1:0] alu_c_o,
    output logic [6:0]            alu_ocode_o,
    input  logic [DATA_WIDTH-1:0] alu_q_i,
    output logic                  wb_en_o,
    output logic [IDX_W-1:0]      wb_idx_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;

    // Counter is one bit wider than the index so vl = VLEN_MAX never wraps.
    logic [IDX_W:0]        r_cnt;
    logic [IDX_W:0]        r_vl;
    logic                  r_masked;
    logic [6:0]            r_ocode;

    logic                  r_alu_valid;
    logic                  r_alu_mask;
    logic                  r_alu_active;
    logic [IDX_W-1:0]      r_alu_idx;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [DATA_WIDTH-1:0] r_alu_c;

    // Tracker: stage k holds the element issued to the ALU k+1 cycles ago;
    // the last stage lines up with alu_q_i.
    logic [PIPE_ST-1:0]    r_trk_vld;
    logic [PIPE_ST-1:0]    r_trk_act;
    logic [IDX_W-1:0]      r_trk_idx [PIPE_ST];

    logic                  r_done;

    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_last;
    logic                  w_inflight;
    logic                  w_done_nxt;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_done_nxt  = 1'b0;
        w_last      = ((r_cnt + CNT_ONE) == r_vl);
        // Elements still in flight after this cycle's shift: anything at the
        // ALU input or in any tracker stage except the one retiring now.
        w_inflight  = r_alu_valid;
        for (int i = 0; i < PIPE_ST - 1; i++) begin
            w_inflight = w_inflight | r_trk_vld[i];
        end
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_accept = 1'b1;
                    if (req_vl_i == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_rd_en = !stall_i;
                if (!stall_i && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_inflight) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt        <= '0;
            r_vl         <= '0;
            r_masked     <= 1'b0;
            r_ocode      <= '0;
            r_alu_valid  <= 1'b0;
            r_alu_mask   <= 1'b0;
            r_alu_active <= 1'b0;
            r_alu_idx    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_c      <= '0;
            r_trk_vld    <= '0;
            r_trk_act    <= '0;
            for (int i = 0; i < PIPE_ST; i++) begin
                r_trk_idx[i] <= '0;
            end
            r_done       <= 1'b0;
        end else begin
            r_done      <= w_done_nxt;
            r_alu_valid <= w_rd_en;

            if (w_accept) begin
                r_ocode  <= req_ocode_i;
                r_vl     <= req_vl_i;
                r_masked <= req_masked_i;
                r_cnt    <= '0;
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // Masked-off elements are still issued; the mask bit doubles as
            // carry-in, so it is forwarded regardless of masking.
            if (w_rd_en) begin
                r_alu_a      <= rd_a_i;
                r_alu_b      <= rd_b_i;
                r_alu_c      <= rd_c_i;
                r_alu_mask   <= rd_mask_i;
                r_alu_active <= !r_masked | rd_mask_i;
                r_alu_idx    <= r_cnt[IDX_W-1:0];
            end

            // The tracker follows the ALU pipeline, which never stalls.
            r_trk_vld[0] <= r_alu_valid;
            r_trk_act[0] <= r_alu_active;
            r_trk_idx[0] <= r_alu_idx;
            for (int i = 1; i < PIPE_ST; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_act[i] <= r_trk_act[i-1];
                r_trk_idx[i] <= r_trk_idx[i-1];
            end
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign rd_en_o      = w_rd_en;
    assign rd_idx_o     = r_cnt[IDX_W-1:0];
    assign alu_valid_o  = r_alu_valid;
    assign alu_mask_e_o = r_alu_mask;
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign alu_c_o      = r_alu_c;
    assign alu_ocode_o  = r_ocode;
    assign wb_en_o      = r_trk_vld[PIPE_ST-1] & r_trk_act[PIPE_ST-1];
    assign wb_idx_o     = r_trk_idx[PIPE_ST-1];
    assign wb_data_o    = alu_q_i;
    assign done_o       = r_done;

endmodule

// File: tb/tb_alu_elem_sequencer.sv
// tb/tb_alu_elem_sequencer.sv - scoreboard testbench for alu_elem_sequencer
module tb_alu_elem_sequencer;

    localparam int DW = 32;
    localparam int PS = 3;
    localparam int VM = 32;
    localparam int IW = $clog2(VM);

    logic          clk_i;
    logic          resetn_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [6:0]    req_ocode_i;
    logic [IW:0]   req_vl_i;
    logic          req_masked_i;
    logic          stall_i;
    logic          rd_en_o;
    logic [IW-1:0] rd_idx_o;
    logic [DW-1:0] rd_a_i, rd_b_i, rd_c_i;
    logic          rd_mask_i;
    logic          alu_valid_o;
    logic          alu_mask_e_o;
    logic [DW-1:0] alu_a_o, alu_b_o, alu_c_o;
    logic [6:0]    alu_ocode_o;
    logic [DW-1:0] alu_q_i;
    logic          wb_en_o;
    logic [IW-1:0] wb_idx_o;
    logic [DW-1:0] wb_data_o;
    logic          busy_o;
    logic          done_o;

    alu_elem_sequencer #(
        .DATA_WIDTH(DW),
        .PIPE_ST   (PS),
        .VLEN_MAX  (VM)
    ) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_ocode_i (req_ocode_i),
        .req_vl_i    (req_vl_i),
        .req_masked_i(req_masked_i),
        .stall_i     (stall_i),
        .rd_en_o     (rd_en_o),
        .rd_idx_o    (rd_idx_o),
        .rd_a_i      (rd_a_i),
        .rd_b_i      (rd_b_i),
        .rd_c_i      (rd_c_i),
        .rd_mask_i   (rd_mask_i),
        .alu_valid_o (alu_valid_o),
        .alu_mask_e_o(alu_mask_e_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_c_o     (alu_c_o),
        .alu_ocode_o (alu_ocode_o),
        .alu_q_i     (alu_q_i),
        .wb_en_o     (wb_en_o),
        .wb_idx_o    (wb_idx_o),
        .wb_data_o   (wb_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc;
    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks;
    int errors;

    // Register file of the lane
    logic [DW-1:0] rf_a [VM];
    logic [DW-1:0] rf_b [VM];
    logic [DW-1:0] rf_c [VM];
    logic          rf_m [VM];
    assign rd_a_i    = rf_a[rd_idx_o];
    assign rd_b_i    = rf_b[rd_idx_o];
    assign rd_c_i    = rf_c[rd_idx_o];
    assign rd_mask_i = rf_m[rd_idx_o];

    function automatic logic [DW-1:0] alu_fn(input logic [6:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] c,
                                             input logic m);
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b ^ c;
            3'd4:    return a + b + {{(DW-1){1'b0}}, m};
            3'd5:    return a * b + c;
            default: return (a | c) ^ {op, 25'd0};
        endcase
    endfunction

    // ALU environment: fixed PS-cycle latency, garbage when no valid input
    logic [DW-1:0] apipe [PS+1];
    initial begin
        for (int i = 0; i <= PS; i++) apipe[i] = '0;
        alu_q_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            for (int i = PS; i > 0; i--) apipe[i] = apipe[i-1];
            apipe[0] = alu_valid_o ? alu_fn(alu_ocode_o, alu_a_o, alu_b_o, alu_c_o, alu_mask_e_o)
                                   : DW'($urandom);
            alu_q_i = apipe[PS];
        end
    end

    typedef struct {
        int            cyc;
        logic [IW-1:0] idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic          m;
        logic [6:0]    op;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_alu[$];
    ev_t q_wb[$];
    int  q_done[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard, mid-cycle
    initial begin
        ev_t e;
        forever begin
            @(negedge clk_i);
            while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
                e = q_rd.pop_front();
                chk("rd_missed", 64'(e.cyc), 64'(cyc));
            end
            while (q_alu.size() > 0 && q_alu[0].cyc < cyc) begin
                e = q_alu.pop_front();
                chk("alu_missed", 64'(e.cyc), 64'(cyc));
            end
            while (q_wb.size() > 0 && q_wb[0].cyc < cyc) begin
                e = q_wb.pop_front();
                chk("wb_missed", 64'(e.cyc), 64'(cyc));
            end
            while (q_done.size() > 0 && q_done[0] < cyc) begin
                chk("done_missed", 64'(q_done.pop_front()), 64'(cyc));
            end
            if (rd_en_o) begin
                if (q_rd.size() == 0 || q_rd[0].cyc != cyc) chk("rd_unexpected", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_idx", 64'(rd_idx_o), 64'(e.idx));
                end
            end
            if (alu_valid_o) begin
                if (q_alu.size() == 0 || q_alu[0].cyc != cyc) chk("alu_unexpected", 1, 0);
                else begin
                    e = q_alu.pop_front();
                    chk("alu_a", 64'(alu_a_o), 64'(e.a));
                    chk("alu_b", 64'(alu_b_o), 64'(e.b));
                    chk("alu_c", 64'(alu_c_o), 64'(e.c));
                    chk("alu_mask_e", 64'(alu_mask_e_o), 64'(e.m));
                    chk("alu_ocode", 64'(alu_ocode_o), 64'(e.op));
                end
            end
            if (wb_en_o) begin
                if (q_wb.size() == 0 || q_wb[0].cyc != cyc) chk("wb_unexpected", 64'(wb_idx_o), 64'hFFFF);
                else begin
                    e = q_wb.pop_front();
                    chk("wb_idx", 64'(wb_idx_o), 64'(e.idx));
                    chk("wb_data", 64'(wb_data_o), 64'(e.a));
                end
            end
            if (done_o) begin
                if (q_done.size() == 0 || q_done[0] != cyc) chk("done_unexpected", 1, 0);
                else chk("done_cyc", 64'(q_done.pop_front()), 64'(cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_o), 1);
        chk({tag, "_busy"}, 64'(busy_o), 0);
        chk({tag, "_rd_en"}, 64'(rd_en_o), 0);
        chk({tag, "_alu_valid"}, 64'(alu_valid_o), 0);
        chk({tag, "_alu_mask_e"}, 64'(alu_mask_e_o), 0);
        chk({tag, "_alu_ops"}, 64'(alu_a_o | alu_b_o | alu_c_o), 0);
        chk({tag, "_alu_ocode"}, 64'(alu_ocode_o), 0);
        chk({tag, "_wb_en"}, 64'(wb_en_o), 0);
        chk({tag, "_wb_idx"}, 64'(wb_idx_o), 0);
        chk({tag, "_done"}, 64'(done_o), 0);
    endtask

    // Issues one request and drives it to its done cycle. Called at posedge+1;
    // returns at posedge+1 of the done cycle so a following call is accepted there.
    task automatic run_req(input logic [6:0] op, input int vl, input bit masked,
                           input int stall_pct, input int stall_at, input bit hold,
                           input int abort_at, input bit pat_mask);
        int  t0, k, c, off_done, w;
        int  rdoff[VM];
        bit  st[256];
        ev_t e;
        w = 0;
        while (req_ready_o !== 1'b1 && w < 200) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        chk("ready_wait", 64'(req_ready_o), 1);
        for (int i = 0; i < VM; i++) begin
            rf_a[i] = $urandom;
            rf_b[i] = $urandom;
            rf_c[i] = $urandom;
            rf_m[i] = pat_mask ? ~i[0] : 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 256; i++) st[i] = (i < 100) && ($urandom_range(0, 99) < stall_pct);
        if (stall_at >= 0) st[stall_at] = 1'b1;
        t0 = cyc;
        // Reads happen in successive non-stalled cycles after acceptance
        k = 0;
        c = 1;
        while (k < vl) begin
            if (!st[c]) begin
                rdoff[k] = c;
                k++;
            end
            c++;
        end
        for (int i = 0; i < vl; i++) begin
            e.idx = IW'(i);
            e.a   = rf_a[i];
            e.b   = rf_b[i];
            e.c   = rf_c[i];
            e.m   = rf_m[i];
            e.op  = op;
            e.cyc = t0 + rdoff[i];
            q_rd.push_back(e);
            e.cyc = t0 + rdoff[i] + 1;
            q_alu.push_back(e);
            if (!masked || rf_m[i]) begin
                e.cyc = t0 + rdoff[i] + PS + 1;
                e.a   = alu_fn(op, rf_a[i], rf_b[i], rf_c[i], rf_m[i]);
                q_wb.push_back(e);
            end
        end
        if (vl == 0) off_done = 1;
        else off_done = rdoff[vl-1] + PS + 2;
        q_done.push_back(t0 + off_done);

        req_valid_i  = 1'b1;
        req_ocode_i  = op;
        req_vl_i     = vl[IW:0];
        req_masked_i = masked;
        stall_i      = st[0];
        for (int o = 1; o < off_done; o++) begin
            @(posedge clk_i);
            #1;
            if (o == abort_at) begin
                resetn_i    = 1'b0;
                req_valid_i = 1'b0;
                stall_i     = 1'b0;
                #1;
                check_reset_outputs("abort");
                q_rd.delete();
                q_alu.delete();
                q_wb.delete();
                q_done.delete();
                return;
            end
            if (hold) begin
                req_valid_i  = 1'b1;
                req_ocode_i  = 7'($urandom);
                req_vl_i     = (IW+1)'($urandom_range(1, VM));
                req_masked_i = 1'($urandom_range(0, 1));
            end else begin
                req_valid_i = 1'b0;
            end
            stall_i = st[o];
            chk("ready_low_busy", 64'(req_ready_o), 0);
            chk("busy_high", 64'(busy_o), 1);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        stall_i     = 1'b0;
        chk("ready_at_done", 64'(req_ready_o), 1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        resetn_i     = 1'b0;
        req_valid_i  = 1'b0;
        req_ocode_i  = '0;
        req_vl_i     = '0;
        req_masked_i = 1'b0;
        stall_i      = 1'b0;
        for (int i = 0; i < VM; i++) begin
            rf_a[i] = '0;
            rf_b[i] = '0;
            rf_c[i] = '0;
            rf_m[i] = 1'b0;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        resetn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic VADD, vl=4
        run_req(7'd0, 4, 1'b0, 0, -1, 1'b0, 0, 1'b0);
        // vl=0
        run_req(7'd1, 0, 1'b0, 0, -1, 1'b0, 0, 1'b0);
        // masked 1,0,1,0
        run_req(7'd4, 4, 1'b1, 0, -1, 1'b0, 0, 1'b1);
        // stall in cycle 2
        run_req(7'd0, 4, 1'b0, 0, 2, 1'b0, 0, 1'b0);
        // reset in cycle 6, then a vl=2 request
        run_req(7'd0, 4, 1'b0, 0, -1, 1'b0, 6, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        repeat (PS + 4) @(posedge clk_i);
        #1;
        run_req(7'd5, 2, 1'b0, 0, -1, 1'b0, 0, 1'b0);
        // held-high valid, two vl=1 requests back to back
        run_req(7'd3, 1, 1'b0, 0, -1, 1'b1, 0, 1'b0);
        run_req(7'd6, 1, 1'b0, 0, -1, 1'b1, 0, 1'b0);
        // full length, masked, with stalls
        run_req(7'd2, VM, 1'b1, 30, -1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_req(7'($urandom_range(0, 127)), $urandom_range(0, VM), 1'($urandom_range(0, 1)),
                    25, -1, ($urandom_range(0, 3) == 0), 0, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end

        repeat (PS + 5) @(posedge clk_i);
        #1;
        chk("sb_drained", 64'(q_rd.size() + q_alu.size() + q_wb.size() + q_done.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
